// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage: PC, two-word instruction assembly and IF/ID register.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_stage #(
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [INSTR_W-1:0] if_id_imm_o,
    output logic [PC_W-1:0]    if_id_pc_next_o,
    output logic               if_id_valid_o
);

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    localparam logic [4:0] C_OP_LDM = 5'b11010;
    localparam logic [4:0] C_OP_LDD = 5'b00111;
    localparam logic [4:0] C_OP_STD = 5'b01100;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] hold_op_q, hold_op_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic [PC_W-1:0]    pc_next_q, pc_next_d;
    logic               valid_q, valid_d;

    logic               w_two_word;
    logic [PC_W-1:0]    w_pc_inc;

    assign w_two_word = (imem_data_i[15:11] == C_OP_LDM) ||
                        (imem_data_i[15:11] == C_OP_LDD) ||
                        (imem_data_i[15:11] == C_OP_STD);
    assign w_pc_inc   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_op_d = hold_op_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        if (redirect_i) begin
            // Any half-fetched two-word instruction is dropped with the flush.
            pc_d      = redirect_pc_i;
            state_d   = FETCH_OP;
            instr_d   = '0;
            imm_d     = '0;
            pc_next_d = '0;
            valid_d   = 1'b0;
        end else if (!stall_i) begin
            pc_d = w_pc_inc;
            case (state_q)
                FETCH_OP: begin
                    if (w_two_word) begin
                        hold_op_d = imem_data_i;
                        state_d   = FETCH_IMM;
                        instr_d   = '0;
                        imm_d     = '0;
                        pc_next_d = '0;
                        valid_d   = 1'b0;
                    end else begin
                        instr_d   = imem_data_i;
                        imm_d     = '0;
                        pc_next_d = w_pc_inc;
                        valid_d   = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    instr_d   = hold_op_q;
                    imm_d     = imem_data_i;
                    pc_next_d = w_pc_inc;
                    valid_d   = 1'b1;
                    state_d   = FETCH_OP;
                end
                default: state_d = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            hold_op_q <= '0;
            instr_q   <= '0;
            imm_q     <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_op_q <= hold_op_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign pc_o            = pc_q;
    assign if_id_instr_o   = instr_q;
    assign if_id_imm_o     = imm_q;
    assign if_id_pc_next_o = pc_next_q;
    assign if_id_valid_o   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage: directed checks of fetch_stage against hand values.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [15:0] imem_data_i;
    logic [31:0] pc_o;
    logic [15:0] if_id_instr_o;
    logic [15:0] if_id_imm_o;
    logic [31:0] if_id_pc_next_o;
    logic        if_id_valid_o;

    logic [15:0] mem [0:255];
    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    assign imem_data_i = mem[imem_addr_o[7:0]];

    fetch_stage #(.PC_W(32), .INSTR_W(16), .RESET_PC(32'h0)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_imm_o     (if_id_imm_o),
        .if_id_pc_next_o (if_id_pc_next_o),
        .if_id_valid_o   (if_id_valid_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                          input logic [31:0] pcn, input logic vld, input logic [31:0] pc);
        chk({tag, ".instr"},   {16'h0, if_id_instr_o},   {16'h0, ins});
        chk({tag, ".imm"},     {16'h0, if_id_imm_o},     {16'h0, imm});
        chk({tag, ".pc_next"}, if_id_pc_next_o,          pcn);
        chk({tag, ".valid"},   {31'h0, if_id_valid_o},   {31'h0, vld});
        chk({tag, ".pc"},      pc_o,                     pc);
        chk({tag, ".addr"},    imem_addr_o,              pc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1800;
        mem[1]   = 16'h8000;
        mem[4]   = 16'hD000;
        mem[5]   = 16'h00AB;
        mem[8]   = 16'h6000;
        mem[9]   = 16'h9800;
        mem[10]  = 16'h0800;
        mem[8'h20] = 16'h3800;
        mem[8'h21] = 16'h1234;
        mem[8'h40] = 16'h1000;
        mem[8'hFF] = 16'h2000;

        rst_ni = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        // Reset held for two edges
        tick();
        tick();
        chk_if("reset", 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
        rst_ni = 1'b1;
        tick();
        chk_if("first", 16'h1800, 16'h0, 32'h1, 1'b1, 32'h1);
        tick();
        chk_if("second", 16'h8000, 16'h0, 32'h2, 1'b1, 32'h2);

        // LDM at 4
        redirect_i = 1'b1; redirect_pc_i = 32'h4;
        tick();
        redirect_i = 1'b0;
        chk_if("redir4", 16'h0, 16'h0, 32'h0, 1'b0, 32'h4);
        tick();
        chk_if("ldm_bubble", 16'h0, 16'h0, 32'h0, 1'b0, 32'h5);
        tick();
        chk_if("ldm", 16'hD000, 16'h00AB, 32'h6, 1'b1, 32'h6);

        // Stall with 0x9800 held, pc=10
        redirect_i = 1'b1; redirect_pc_i = 32'h9;
        tick();
        redirect_i = 1'b0;
        tick();
        chk_if("pre_stall", 16'h9800, 16'h0, 32'hA, 1'b1, 32'hA);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_if("stall", 16'h9800, 16'h0, 32'hA, 1'b1, 32'hA);
        end
        stall_i = 1'b0;
        tick();
        chk_if("resume", 16'h0800, 16'h0, 32'hB, 1'b1, 32'hB);

        // Redirect during FETCH_IMM of STD at 8
        redirect_i = 1'b1; redirect_pc_i = 32'h8;
        tick();
        redirect_i = 1'b0;
        tick();
        chk_if("std_bubble", 16'h0, 16'h0, 32'h0, 1'b0, 32'h9);
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        chk_if("std_abandon", 16'h0, 16'h0, 32'h0, 1'b0, 32'h40);
        tick();
        chk_if("after_abandon", 16'h1000, 16'h0, 32'h41, 1'b1, 32'h41);

        // Redirect beats stall
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h20;
        tick();
        stall_i = 1'b0; redirect_i = 1'b0;
        chk_if("stall_redir", 16'h0, 16'h0, 32'h0, 1'b0, 32'h20);
        tick();
        chk_if("ldd_bubble", 16'h0, 16'h0, 32'h0, 1'b0, 32'h21);

        // Reset while in FETCH_IMM discards the LDD opcode
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk_if("rst_imm", 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
        tick();
        chk_if("post_rst", 16'h1800, 16'h0, 32'h1, 1'b1, 32'h1);

        // PC wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        chk("wrap_pc_set", pc_o, 32'hFFFF_FFFF);
        tick();
        chk_if("wrap", 16'h2000, 16'h0, 32'h0, 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
